// File: rtl/tcm_pkg.sv
// Shared TCM constants and request bundle for the tightly-coupled-memory arbiter.
// Optional round-robin arbitration is enabled with the TCM_ARB_RR_EN macro.
package tcm_pkg;

    localparam int TCM_DATA_WIDTH = 32;
    localparam int TCM_ADDR_WIDTH = 15;
    localparam int TCM_NUM_PORTS  = 2;

    // Encoding of the round-robin "last granted" pointer.
    localparam logic PTR_PORT0 = 1'b0;
    localparam logic PTR_PORT1 = 1'b1;

    typedef struct packed {
        logic [TCM_ADDR_WIDTH-1:0]   addr;
        logic                        we;
        logic [TCM_DATA_WIDTH/8-1:0] be;
        logic [TCM_DATA_WIDTH-1:0]   wdata;
    } tcm_req_t;

endpackage

// File: rtl/tcm_arb_if.sv
// Requester-side bundle of the two-port TCM arbiter: master = requesters, slave = arbiter.
// Used identically whether or not TCM_ARB_RR_EN is defined.
interface tcm_arb_if
    import tcm_pkg::*;
#(
    parameter int DATA_WIDTH = TCM_DATA_WIDTH,
    parameter int ADDR_WIDTH = TCM_ADDR_WIDTH
);
    logic [TCM_NUM_PORTS-1:0]                    req;
    logic [TCM_NUM_PORTS-1:0]                    gnt;
    logic [TCM_NUM_PORTS-1:0][ADDR_WIDTH-1:0]    addr;
    logic [TCM_NUM_PORTS-1:0]                    we;
    logic [TCM_NUM_PORTS-1:0][DATA_WIDTH/8-1:0]  be;
    logic [TCM_NUM_PORTS-1:0][DATA_WIDTH-1:0]    wdata;
    logic [TCM_NUM_PORTS-1:0]                    rvalid;
    logic [TCM_NUM_PORTS-1:0]                    err;
    logic [DATA_WIDTH-1:0]                       rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/tcm_arb_sel.sv
// Grant decision for the two TCM ports: fixed priority (port 0 wins) by default,
// round-robin with a "last granted" pointer when TCM_ARB_RR_EN is defined.
module tcm_arb_sel
    import tcm_pkg::*;
(
`ifdef TCM_ARB_RR_EN
    input  logic     clk_i,
`endif
    input  logic     rst_i,
    tcm_arb_if.slave bus
);

`ifdef TCM_ARB_RR_EN
    logic last_q;

    // On contention the port that did not win most recently gets the TCM.
    always_comb begin
        bus.gnt = 2'b00;
        if (!rst_i) begin
            if (bus.req == 2'b11) begin
                bus.gnt = (last_q == PTR_PORT1) ? 2'b01 : 2'b10;
            end else begin
                bus.gnt = bus.req;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= PTR_PORT1;
        end else if (bus.gnt != 2'b00) begin
            last_q <= bus.gnt[1];
        end
    end
`else
    always_comb begin
        bus.gnt = 2'b00;
        if (!rst_i) begin
            bus.gnt[0] = bus.req[0];
            bus.gnt[1] = bus.req[1] & ~bus.req[0];
        end
    end
`endif

endmodule

// File: rtl/tcm_arb.sv
// Two-port TCM arbiter: same-cycle grant, request mux to the TCM macro and a
// one-entry response register. Define TCM_ARB_RR_EN for round-robin arbitration.
module tcm_arb
    import tcm_pkg::*;
#(
    parameter int DATA_WIDTH = TCM_DATA_WIDTH,
    parameter int ADDR_WIDTH = TCM_ADDR_WIDTH
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [TCM_NUM_PORTS-1:0]                   p_req_i,
    output logic [TCM_NUM_PORTS-1:0]                   p_gnt_o,
    input  logic [TCM_NUM_PORTS-1:0][ADDR_WIDTH-1:0]   p_addr_i,
    input  logic [TCM_NUM_PORTS-1:0]                   p_we_i,
    input  logic [TCM_NUM_PORTS-1:0][DATA_WIDTH/8-1:0] p_be_i,
    input  logic [TCM_NUM_PORTS-1:0][DATA_WIDTH-1:0]   p_wdata_i,
    output logic [TCM_NUM_PORTS-1:0]                   p_rvalid_o,
    output logic [TCM_NUM_PORTS-1:0]                   p_err_o,
    output logic [DATA_WIDTH-1:0]                      p_rdata_o,
    output logic                                       tcm_en_o,
    output logic [ADDR_WIDTH-1:0]                      tcm_addr_o,
    output logic                                       tcm_we_o,
    output logic [DATA_WIDTH/8-1:0]                    tcm_be_o,
    output logic [DATA_WIDTH-1:0]                      tcm_wdata_o,
    input  logic [DATA_WIDTH-1:0]                      tcm_rdata_i
);

    tcm_arb_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    logic any_gnt;
    logic sel;
    logic aligned;
    logic rsp_valid_q;
    logic rsp_port_q;
    logic rsp_read_q;
    logic rsp_err_q;

    assign bus.req    = p_req_i;
    assign bus.addr   = p_addr_i;
    assign bus.we     = p_we_i;
    assign bus.be     = p_be_i;
    assign bus.wdata  = p_wdata_i;
    assign p_gnt_o    = bus.gnt;
    assign p_rvalid_o = bus.rvalid;
    assign p_err_o    = bus.err;
    assign p_rdata_o  = bus.rdata;

    tcm_arb_sel u_sel (
`ifdef TCM_ARB_RR_EN
        .clk_i (clk_i),
`endif
        .rst_i (rst_i),
        .bus   (bus)
    );

    assign any_gnt = |bus.gnt;
    assign sel     = bus.gnt[1];

    // Idle cycles park the macro bus at zero so the TCM sees no stray toggles.
    always_comb begin
        tcm_addr_o  = '0;
        tcm_we_o    = 1'b0;
        tcm_be_o    = '0;
        tcm_wdata_o = '0;
        if (any_gnt) begin
            tcm_addr_o  = bus.addr[sel];
            tcm_we_o    = bus.we[sel];
            tcm_be_o    = bus.be[sel];
            tcm_wdata_o = bus.wdata[sel];
        end
    end

    assign aligned  = (tcm_addr_o[1:0] == 2'b00);
    assign tcm_en_o = any_gnt & aligned;

    // Misaligned accesses are granted but never reach the macro; they return an error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_read_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= any_gnt;
            if (any_gnt) begin
                rsp_port_q <= sel;
                rsp_read_q <= ~tcm_we_o;
                rsp_err_q  <= ~aligned;
            end
        end
    end

    assign bus.rvalid[0] = rsp_valid_q & ~rsp_port_q;
    assign bus.rvalid[1] = rsp_valid_q &  rsp_port_q;
    assign bus.err       = bus.rvalid & {TCM_NUM_PORTS{rsp_err_q}};
    assign bus.rdata     = (rsp_valid_q & rsp_read_q & ~rsp_err_q) ? tcm_rdata_i : '0;

endmodule

// File: tb/tb_tcm_arb.sv
// Scoreboard bench for tcm_arb: directed scenarios then random traffic against a
// rule-level arbitration model and a shadow memory; honours TCM_ARB_RR_EN.
`timescale 1ns/1ps
module tb_tcm_arb;
    import tcm_pkg::*;

    localparam int DW    = TCM_DATA_WIDTH;
    localparam int AW    = TCM_ADDR_WIDTH;
    localparam int BW    = DW / 8;
    localparam int WORDS = 1 << (AW - 2);

    typedef struct {
        int            port;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tcm_en;
    logic          tcm_we;
    logic [AW-1:0] tcm_addr;
    logic [BW-1:0] tcm_be;
    logic [DW-1:0] tcm_wdata;
    logic [DW-1:0] tcm_rdata = '0;

    logic [DW-1:0] tcm_mem [WORDS];
    logic [DW-1:0] ref_mem [WORDS];
    exp_t          exp_q [$];
    logic          last_port;
    int            checks = 0;
    int            passed = 0;

    tcm_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    tcm_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .p_req_i     (bus.req),
        .p_gnt_o     (bus.gnt),
        .p_addr_i    (bus.addr),
        .p_we_i      (bus.we),
        .p_be_i      (bus.be),
        .p_wdata_i   (bus.wdata),
        .p_rvalid_o  (bus.rvalid),
        .p_err_o     (bus.err),
        .p_rdata_o   (bus.rdata),
        .tcm_en_o    (tcm_en),
        .tcm_addr_o  (tcm_addr),
        .tcm_we_o    (tcm_we),
        .tcm_be_o    (tcm_be),
        .tcm_wdata_o (tcm_wdata),
        .tcm_rdata_i (tcm_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural TCM macro: byte-enabled writes, read data one cycle after enable.
    always @(posedge clk) begin
        if (tcm_en) begin
            if (tcm_we) begin
                for (int b = 0; b < BW; b++)
                    if (tcm_be[b]) tcm_mem[tcm_addr[AW-1:2]][b*8 +: 8] = tcm_wdata[b*8 +: 8];
            end else begin
                tcm_rdata <= tcm_mem[tcm_addr[AW-1:2]];
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic tcm_req_t mk(input logic [AW-1:0] a, input logic w,
                                    input logic [BW-1:0] be, input logic [DW-1:0] d);
        tcm_req_t r;
        r.addr  = a;
        r.we    = w;
        r.be    = be;
        r.wdata = d;
        return r;
    endfunction

    function automatic tcm_req_t rnd_req();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return mk(a, 1'($urandom), BW'($urandom), DW'($urandom));
    endfunction

    // Drive one cycle of requests, check the grant-cycle outputs and queue the expected response.
    task automatic apply_stimulus(input logic [1:0] req, input tcm_req_t r0, input tcm_req_t r1);
        tcm_req_t w;
        exp_t     e;
        int       win;
        logic     mis;
        @(negedge clk);
        bus.req      = req;
        bus.addr[0]  = r0.addr;  bus.addr[1]  = r1.addr;
        bus.we[0]    = r0.we;    bus.we[1]    = r1.we;
        bus.be[0]    = r0.be;    bus.be[1]    = r1.be;
        bus.wdata[0] = r0.wdata; bus.wdata[1] = r1.wdata;
        #1;
        win = -1;
        if (req == 2'b11) begin
`ifdef TCM_ARB_RR_EN
            win = last_port ? 0 : 1;
`else
            win = 0;
`endif
        end else if (req[0]) win = 0;
        else if (req[1]) win = 1;

        if (win < 0) begin
            check_output("gnt_idle", bus.gnt, 0);
            check_output("tcm_en_idle", tcm_en, 0);
            check_output("tcm_bus_idle", {tcm_addr, tcm_we, tcm_be, tcm_wdata}, 0);
        end else begin
            w   = (win == 0) ? r0 : r1;
            mis = (w.addr[1:0] != 2'b00);
            check_output("gnt", bus.gnt, 64'(2'b01 << win));
            check_output("tcm_en", tcm_en, !mis);
            check_output("tcm_bus", {tcm_addr, tcm_we, tcm_be, tcm_wdata},
                         {w.addr, w.we, w.be, w.wdata});
            e.port  = win;
            e.err   = mis;
            e.rdata = (!mis && !w.we) ? ref_mem[w.addr[AW-1:2]] : '0;
            if (!mis && w.we)
                for (int b = 0; b < BW; b++)
                    if (w.be[b]) ref_mem[w.addr[AW-1:2]][b*8 +: 8] = w.wdata[b*8 +: 8];
            exp_q.push_back(e);
            last_port = win[0];
        end
    endtask

    // Monitor: one response is owed exactly one cycle after each grant, none otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            check_output("rvalid_none", bus.rvalid, 0);
        end else begin
            e = exp_q.pop_front();
            check_output("rvalid", bus.rvalid, 64'(2'b01 << e.port));
            check_output("err", bus.err, e.err ? 64'(2'b01 << e.port) : 64'd0);
            check_output("rdata", bus.rdata, e.rdata);
        end
    end

    initial begin
        tcm_req_t z;
        z = mk('0, 1'b0, '0, '0);
        for (int i = 0; i < WORDS; i++) begin
            tcm_mem[i] = DW'(i * 32'h9E37_79B1) ^ 32'hA5A5_0000;
            ref_mem[i] = DW'(i * 32'h9E37_79B1) ^ 32'hA5A5_0000;
        end
        tcm_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        bus.req = '0; bus.addr = '0; bus.we = '0; bus.be = '0; bus.wdata = '0;
        last_port = 1'b1;

        @(negedge clk);
        bus.req = 2'b11;
        #1;
        check_output("reset_gnt", bus.gnt, 0);
        check_output("reset_tcm_en", tcm_en, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 2'b00;

        $display("[TB] directed scenarios");
        apply_stimulus(2'b01, mk(15'h0010, 1'b0, 4'hF, '0), z);
        apply_stimulus(2'b10, z, mk(15'h0022, 1'b1, 4'hF, 32'hCAFE_0001));
        for (int i = 0; i < 4; i++)
            apply_stimulus(2'b11, mk(15'h0030, 1'b0, 4'hF, '0),
                           mk(15'h0034, 1'b1, 4'hF, DW'($urandom)));
        apply_stimulus(2'b01, mk(15'h0100, 1'b1, 4'b0011, 32'h1234_5678), z);
        apply_stimulus(2'b01, mk(15'h0100, 1'b0, 4'hF, '0), z);
        check_output("rmw_low_half", ref_mem[15'h0100 >> 2][15:0], 16'h5678);
        apply_stimulus(2'b00, z, z);

        $display("[TB] reset after grant");
        apply_stimulus(2'b10, z, mk(15'h0020, 1'b0, 4'hF, '0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        last_port = 1'b1;
        @(negedge clk);
        bus.req = 2'b11;
        #1;
        check_output("reset_gnt_held", bus.gnt, 0);
        check_output("reset_tcm_en_held", tcm_en, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 2'b00;
        apply_stimulus(2'b11, mk(15'h0040, 1'b0, 4'hF, '0), mk(15'h0044, 1'b0, 4'hF, '0));

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++)
            apply_stimulus(2'($urandom_range(0, 3)), rnd_req(), rnd_req());
        apply_stimulus(2'b00, z, z);

        repeat (2) @(negedge clk);
        #2;
        check_output("queue_drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tcm_arb.md
TCM_ARB -- requirements
Module: tcm_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, TCM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 15, byte address width (8192 words x 4 B).
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port p_req_i, input, [1:0], per-port request; port 0 is core LSU, port 1 is DMA/debug.
REQ-006 SHALL have port p_gnt_o, output, [1:0], per-port grant.
REQ-007 SHALL have port p_addr_i, input, [1:0][ADDR_WIDTH-1:0], per-port byte address.
REQ-008 SHALL have port p_we_i, input, [1:0], per-port write enable.
REQ-009 SHALL have port p_be_i, input, [1:0][DATA_WIDTH/8-1:0], per-port byte enables.
REQ-010 SHALL have port p_wdata_i, input, [1:0][DATA_WIDTH-1:0], per-port write data.
REQ-011 SHALL have port p_rvalid_o, output, [1:0], per-port response valid.
REQ-012 SHALL have port p_err_o, output, [1:0], per-port error, qualified by p_rvalid_o.
REQ-013 SHALL have port p_rdata_o, output, [DATA_WIDTH-1:0], shared read data, qualified by p_rvalid_o.
REQ-014 SHALL have ports tcm_en_o, tcm_addr_o [ADDR_WIDTH-1:0], tcm_we_o, tcm_be_o [DATA_WIDTH/8-1:0], tcm_wdata_o [DATA_WIDTH-1:0], all outputs, TCM macro request.
REQ-015 SHALL have port tcm_rdata_i, input, [DATA_WIDTH-1:0], TCM read data, valid one cycle after a read enable.

Function
REQ-016 SHALL grant at most one port per cycle, combinationally in the same cycle as p_req_i; p_gnt_o is one-hot or zero.
REQ-017 SHALL, without contention, grant the sole requester; with contention, choose per REQ-029/030.
REQ-018 SHALL drive the tcm_* outputs from the granted port's signals in the grant cycle; tcm_en_o = granted AND address aligned.
REQ-019 SHALL treat addr[1:0] != 0 as misaligned: grant, keep tcm_en_o low, and set p_err_o with p_rvalid_o in the next cycle.
REQ-020 SHALL assert p_rvalid_o[k] for exactly one cycle, exactly one cycle after every grant to port k, for both reads and writes.
REQ-021 SHALL drive p_rdata_o = tcm_rdata_i when the response is an aligned read; otherwise p_rdata_o = 0.
REQ-022 SHALL register response state (port id, valid, is_read, err) in a one-entry pipeline register; back-to-back grants every cycle are supported, throughput 1 access/cycle.
REQ-023 SHALL keep a granted requester's request unmasked for its response; a port may re-request in its rvalid cycle.
REQ-024 SHALL hold tcm_addr_o, tcm_we_o, tcm_be_o and tcm_wdata_o at 0 when no grant occurs.

Reset
REQ-025 SHALL reset p_rvalid_o, p_err_o, response registers and the priority pointer asynchronously on rst_i high.
REQ-026 SHALL drive p_gnt_o = 0 and tcm_en_o = 0 while rst_i is high, regardless of p_req_i.
REQ-027 SHALL drop a response pending at reset assertion; no rvalid follows reset deassertion.
REQ-028 SHALL reset the priority pointer to "port 1 last granted", so port 0 wins the first contention.

Configuration
REQ-029 SHALL, with TCM_ARB_RR_EN defined, arbitrate round-robin: on contention, grant the port not granted most recently; the pointer updates on every grant.
REQ-030 SHALL, without TCM_ARB_RR_EN, use fixed priority with port 0 always winning; the pointer register is not instantiated.

Structure
REQ-031 SHALL place TCM_DATA_WIDTH, TCM_ADDR_WIDTH, TCM_NUM_PORTS and the typedef tcm_req_t {addr, we, be, wdata} in shared package tcm_pkg.
REQ-032 SHALL put the arbitration decision and pointer in one sub-module, tcm_arb_sel; the datapath mux and response register stay in tcm_arb.

Verification
REQ-033 SHALL cover: port 0 reads 0x0010 alone, with the TCM returning 0xDEADBEEF -> gnt[0] in the same cycle, tcm_en_o=1, rvalid[0] the next cycle with rdata 0xDEADBEEF and err 0.
REQ-034 SHALL cover: both ports request every cycle for 4 cycles -> fixed build grants 0,0,0,0; TCM_ARB_RR_EN build grants 0,1,0,1.
REQ-035 SHALL cover: port 1 writes 0x0022 with be=4'b1111 -> gnt[1], tcm_en_o=0, rvalid[1] and err[1] the next cycle.
REQ-036 SHALL cover: back-to-back port 0 write then read of 0x0100 with wdata 0x12345678 and be 4'b0011 -> two rvalids in consecutive cycles; read data lower half is 0x5678.
REQ-037 SHALL cover: rst_i asserted in the cycle after a grant -> no rvalid is produced; after release, the first contention grants port 0.
